// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction width, NOP encoding, default program image and fetch-buffer states.
// The image is consumed by instr_rom_sync in both the constant-table and IMEM_LOAD_EN builds.
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} imem_state_t;

    function automatic logic [INSTR_W-1:0] imem_init(input int unsigned idx);
        logic [INSTR_W-1:0] word;
        case (idx)
            0:       word = 32'h8c01_0001;
            1:       word = 32'h8c02_0002;
            2:       word = 32'h8c03_0003;
            3:       word = 32'h8c04_0004;
            4:       word = 32'h8c05_0005;
            5:       word = 32'h8c06_0006;
            6:       word = 32'h8c07_0007;
            7:       word = 32'h8c08_0008;
            8:       word = 32'h8c09_0009;
            9:       word = 32'h8c0a_000a;
            10:      word = 32'h0022_0018;
            11:      word = 32'h0064_0018;
            12:      word = 32'h00a6_0018;
            30:      word = 32'h8c1e_001e;
            31:      word = 32'h8c1f_001f;
            default: word = NOP;
        endcase
        return word;
    endfunction

    // Lets the top substitute its own NOP_WORD for holes in the image.
    function automatic logic imem_has(input int unsigned idx);
        return (idx <= 12) || (idx == 30) || (idx == 31);
    endfunction

endpackage

// File: rtl/instr_rom_sync_skid.sv
// Response skid buffer for instr_rom_sync: output register plus one skid entry, FIFO order.
// Independent of IMEM_LOAD_EN; W carries the data word with its error flag.
module rsp_skid_buf
    import mips_pkg::*;
#(
    parameter int           W         = 33,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inValid,
    output logic         o_inReady,
    input  logic [W-1:0] i_inData,
    output logic         o_outValid,
    input  logic         i_outReady,
    output logic [W-1:0] o_outData
);

    imem_state_t r_state;
    imem_state_t w_nextState;
    logic [W-1:0] r_or;
    logic [W-1:0] r_sk;
    logic w_push;
    logic w_pop;

    assign w_push = i_inValid & o_inReady;
    assign w_pop  = o_outValid & i_outReady;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            EMPTY:   if (w_push) w_nextState = ONE;
            ONE: begin
                if (w_push && !w_pop)      w_nextState = TWO;
                else if (w_pop && !w_push) w_nextState = EMPTY;
            end
            TWO:     if (w_pop) w_nextState = ONE;
            default: w_nextState = EMPTY;
        endcase
    end

    always_comb begin
        o_inReady  = (r_state != TWO);
        o_outValid = (r_state != EMPTY);
        o_outData  = r_or;
    end

    // The skid entry only fills when the output register is occupied and not draining.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_or <= RESET_VAL;
            r_sk <= RESET_VAL;
        end else begin
            case (r_state)
                EMPTY: if (w_push) r_or <= i_inData;
                ONE: begin
                    if (w_push && w_pop) r_or <= i_inData;
                    else if (w_push)     r_sk <= i_inData;
                end
                TWO:   if (w_pop) r_or <= r_sk;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/instr_rom_sync.sv
// Registered instruction memory with valid/ready fetch and skid-buffered responses.
// Define IMEM_LOAD_EN for a writable register array with a load port; otherwise a constant ROM.
module instr_rom_sync
    import mips_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 5,
    parameter int                DEPTH    = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err
`ifdef IMEM_LOAD_EN
    ,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    logic              w_reqInRange;
    logic [IDX_W-1:0]  w_reqIdx;
    logic [DATA_W-1:0] w_memWord;
    logic [DATA_W-1:0] w_rdWord;
    logic [DATA_W:0]   w_outEntry;

    function automatic logic [DATA_W-1:0] imageWord(input int unsigned idx);
        return imem_has(idx) ? DATA_W'(imem_init(idx)) : NOP_WORD;
    endfunction

    // Full-width compare so addresses beyond DEPTH never alias onto real words.
    assign w_reqInRange = ({1'b0, req_addr} < DEPTH_LIM);
    assign w_reqIdx     = req_addr[IDX_W-1:0];

`ifdef IMEM_LOAD_EN
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_ldInRange;
    logic [IDX_W-1:0]  w_ldIdx;

    assign w_ldInRange = ({1'b0, ld_addr} < DEPTH_LIM);
    assign w_ldIdx     = ld_addr[IDX_W-1:0];

    // Reads sample the array before this edge's write lands, so a same-address read sees the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= imageWord(i);
            end
        end else if (ld_en && w_ldInRange) begin
            r_mem[w_ldIdx] <= ld_data;
        end
    end

    assign w_memWord = r_mem[w_reqIdx];
`else
    assign w_memWord = imageWord(32'(w_reqIdx));
`endif

    assign w_rdWord = w_reqInRange ? w_memWord : NOP_WORD;

    rsp_skid_buf #(
        .W         (DATA_W + 1),
        .RESET_VAL ({1'b0, NOP_WORD})
    ) u_skid (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_inValid  (req_valid),
        .o_inReady  (req_ready),
        .i_inData   ({!w_reqInRange, w_rdWord}),
        .o_outValid (rsp_valid),
        .i_outReady (rsp_ready),
        .o_outData  (w_outEntry)
    );

    assign rsp_err  = w_outEntry[DATA_W];
    assign rsp_data = w_outEntry[DATA_W-1:0];

endmodule

// File: tb/tb_instr_rom_sync.sv
// Directed bench for instr_rom_sync (DEPTH=16); load-port steps are built when IMEM_LOAD_EN is defined.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_instr_rom_sync;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
`ifdef IMEM_LOAD_EN
    logic        ld_en;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
`endif

    int vectors;
    int miscompares;

    instr_rom_sync #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .DEPTH    (16),
        .NOP_WORD (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
`ifdef IMEM_LOAD_EN
        ,
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [4:0] addr, input logic ready);
        req_valid = valid;
        req_addr  = addr;
        rsp_ready = ready;
    endtask

    task automatic checkOutput(input string tag, input logic expValid, input logic expReady,
                               input logic chkData, input logic [31:0] expData, input logic expErr);
        vectors++;
        assert (rsp_valid === expValid) else begin
            miscompares++;
            $error("[TB] FAIL %s rsp_valid observed %b expected %b", tag, rsp_valid, expValid);
        end
        vectors++;
        assert (req_ready === expReady) else begin
            miscompares++;
            $error("[TB] FAIL %s req_ready observed %b expected %b", tag, req_ready, expReady);
        end
        if (chkData) begin
            vectors++;
            assert (rsp_data === expData) else begin
                miscompares++;
                $error("[TB] FAIL %s rsp_data observed %h expected %h", tag, rsp_data, expData);
            end
            vectors++;
            assert (rsp_err === expErr) else begin
                miscompares++;
                $error("[TB] FAIL %s rsp_err observed %b expected %b", tag, rsp_err, expErr);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        applyStimulus(1'b0, 5'd0, 1'b1);
`ifdef IMEM_LOAD_EN
        ld_en   = 1'b0;
        ld_addr = 5'd0;
        ld_data = 32'h0;
`endif
        tick();
        tick();
        checkOutput("reset", 1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b0);
        rst = 1'b0;
        tick();
        checkOutput("post_reset", 1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b0);

        // Single fetch, then back-to-back streaming
        applyStimulus(1'b1, 5'd0, 1'b1);
        tick();
        checkOutput("fetch0", 1'b1, 1'b1, 1'b1, 32'h8c01_0001, 1'b0);
        applyStimulus(1'b1, 5'd10, 1'b1);
        tick();
        checkOutput("stream10", 1'b1, 1'b1, 1'b1, 32'h0022_0018, 1'b0);
        applyStimulus(1'b1, 5'd11, 1'b1);
        tick();
        checkOutput("stream11", 1'b1, 1'b1, 1'b1, 32'h0064_0018, 1'b0);
        applyStimulus(1'b1, 5'd12, 1'b1);
        tick();
        checkOutput("stream12", 1'b1, 1'b1, 1'b1, 32'h00a6_0018, 1'b0);
        applyStimulus(1'b0, 5'd0, 1'b1);
        tick();
        checkOutput("drain_a", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);

        // Back-pressure fills the skid entry
        applyStimulus(1'b1, 5'd1, 1'b0);
        tick();
        checkOutput("bp_req1", 1'b1, 1'b1, 1'b1, 32'h8c02_0002, 1'b0);
        applyStimulus(1'b1, 5'd2, 1'b0);
        tick();
        checkOutput("bp_full", 1'b1, 1'b0, 1'b1, 32'h8c02_0002, 1'b0);
        applyStimulus(1'b1, 5'd3, 1'b0);
        tick();
        checkOutput("bp_hold", 1'b1, 1'b0, 1'b1, 32'h8c02_0002, 1'b0);
        applyStimulus(1'b0, 5'd0, 1'b1);
        tick();
        checkOutput("bp_pop2", 1'b1, 1'b1, 1'b1, 32'h8c03_0003, 1'b0);
        tick();
        checkOutput("bp_empty", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);

        // Range checks against DEPTH=16
        applyStimulus(1'b1, 5'd20, 1'b1);
        tick();
        checkOutput("oor20", 1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b1);
        applyStimulus(1'b1, 5'd13, 1'b1);
        tick();
        checkOutput("unprog13", 1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b0);
        applyStimulus(1'b1, 5'd16, 1'b1);
        tick();
        checkOutput("oor16", 1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b1);
        applyStimulus(1'b1, 5'd9, 1'b1);
        tick();
        checkOutput("edge9", 1'b1, 1'b1, 1'b1, 32'h8c0a_000a, 1'b0);
        applyStimulus(1'b1, 5'd15, 1'b1);
        tick();
        checkOutput("unprog15", 1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b0);
        applyStimulus(1'b1, 5'd30, 1'b1);
        tick();
        checkOutput("oor30", 1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b1);
        applyStimulus(1'b0, 5'd0, 1'b1);
        tick();
        checkOutput("drain_b", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 5'd20, 1'b0);
        tick();
        checkOutput("oor_stall", 1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b1);
        applyStimulus(1'b0, 5'd0, 1'b0);
        tick();
        checkOutput("oor_hold", 1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b1);
        applyStimulus(1'b0, 5'd0, 1'b1);
        tick();
        checkOutput("drain_c", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);

        // Reset from TWO, and reset racing an accept from EMPTY
        applyStimulus(1'b1, 5'd4, 1'b0);
        tick();
        checkOutput("fill4", 1'b1, 1'b1, 1'b1, 32'h8c05_0005, 1'b0);
        applyStimulus(1'b1, 5'd5, 1'b0);
        tick();
        checkOutput("fill5", 1'b1, 1'b0, 1'b1, 32'h8c05_0005, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b1, 5'd6, 1'b0);
        tick();
        checkOutput("rst_two", 1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b0, 5'd0, 1'b1);
        tick();
        checkOutput("rst_nostale1", 1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b0);
        tick();
        checkOutput("rst_nostale2", 1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b1, 5'd0, 1'b1);
        tick();
        checkOutput("rst_accept", 1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b0, 5'd0, 1'b1);
        tick();
        checkOutput("rst_accept_after", 1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b0);

`ifdef IMEM_LOAD_EN
        // Load port: same-cycle read returns the old word
        ld_en   = 1'b1;
        ld_addr = 5'd5;
        ld_data = 32'hdead_beef;
        applyStimulus(1'b1, 5'd5, 1'b1);
        tick();
        checkOutput("ld_old", 1'b1, 1'b1, 1'b1, 32'h8c06_0006, 1'b0);
        ld_en = 1'b0;
        tick();
        checkOutput("ld_new", 1'b1, 1'b1, 1'b1, 32'hdead_beef, 1'b0);
        ld_en   = 1'b1;
        ld_addr = 5'd16;
        ld_data = 32'h1234_5678;
        applyStimulus(1'b0, 5'd0, 1'b1);
        tick();
        ld_en = 1'b0;
        applyStimulus(1'b1, 5'd0, 1'b1);
        tick();
        checkOutput("ld_oor_ignored", 1'b1, 1'b1, 1'b1, 32'h8c01_0001, 1'b0);
        rst     = 1'b1;
        ld_en   = 1'b1;
        ld_addr = 5'd5;
        ld_data = 32'hcafe_f00d;
        applyStimulus(1'b0, 5'd0, 1'b1);
        tick();
        rst   = 1'b0;
        ld_en = 1'b0;
        applyStimulus(1'b1, 5'd5, 1'b1);
        tick();
        checkOutput("ld_rst_restore", 1'b1, 1'b1, 1'b1, 32'h8c06_0006, 1'b0);
        applyStimulus(1'b0, 5'd0, 1'b1);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
